dmem_ctrl: RTL and testbench

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_ctrl_pkg.sv | 21 ++
 rtl/dmem_lane.sv | 41 ++++
 rtl/dmem_ctrl.sv | 163 ++++++++++++++++
 tb/tb_dmem_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the data-memory controller: access size encodings,
// FSM state encoding and a small size-decoding helper.
package dmem_ctrl_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RMW  = 2'b01,
        RESP = 2'b10
    } state_e;

    // The reserved encoding 2'b11 behaves as a word access, so bit 1 alone
    // identifies a full-word transfer.
    function automatic logic is_word(input logic [1:0] size);
        return size[1];
    endfunction

endpackage

// File: rtl/dmem_lane.sv
// Combinational byte-lane unit: extracts and sign/zero-extends load data from
// a RAM word, and merges right-aligned store data into the addressed lanes.
module dmem_lane
    import dmem_ctrl_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  size_i,
    input  logic [1:0]  lane_i,
    input  logic        unsigned_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Select the addressed byte/half, then extend or merge according to size.
    // Halfword lanes use only lane_i[1], so a stray lane_i[0] is ignored.
    always_comb begin
        byte_sel = word_i[{lane_i, 3'b000} +: 8];
        half_sel = word_i[{lane_i[1], 4'b0000} +: 16];
        load_o   = word_i;
        merge_o  = word_i;
        case (size_i)
            SZ_BYTE: begin
                load_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
                merge_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
            end
            SZ_HALF: begin
                load_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
                merge_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            end
            default: begin
                load_o  = word_i;
                merge_o = wdata_i;
            end
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: bridges a valid/ready core request port to a
// single-cycle RAM with combinational read data. Loads and word stores take
// one RAM cycle; byte/half stores do a read-modify-write over two cycles.
// Optional build macro MISALIGN_TRAP_EN: misaligned half/word accesses are
// refused with rsp_err=1 and no RAM access; otherwise low address bits are
// ignored and rsp_err is constant 0.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int AWIDTH = 8,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [DWIDTH-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DWIDTH-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [31:0]       mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic [DWIDTH-1:0] mem_rdata
);

    state_e              state_q, state_d;
    logic [AWIDTH-1:0]   addr_q, addr_d;
    logic [DWIDTH-1:0]   merge_q, merge_d;
    logic [DWIDTH-1:0]   rdata_q, rdata_d;
    logic [AWIDTH-1:0]   word_idx;
    logic [DWIDTH-1:0]   lane_load;
    logic [DWIDTH-1:0]   lane_merge;
    logic                accept;
    logic                unused_addr;

    assign word_idx    = req_addr[AWIDTH+1:2];
    assign accept      = req_valid && req_ready;
    assign unused_addr = ^req_addr[31:AWIDTH+2];

`ifdef MISALIGN_TRAP_EN
    logic err_q, err_d;
    logic misalign;

    assign misalign = ((req_size == SZ_HALF) && req_addr[0]) ||
                      (is_word(req_size) && (req_addr[1:0] != 2'b00));
    assign rsp_err  = err_q;
`else
    assign rsp_err  = 1'b0;
`endif

    dmem_lane u_lane (
        .word_i     (mem_rdata),
        .wdata_i    (req_wdata),
        .size_i     (req_size),
        .lane_i     (req_addr[1:0]),
        .unsigned_i (req_unsigned),
        .load_o     (lane_load),
        .merge_o    (lane_merge)
    );

    assign rsp_rdata = rdata_q;

    // Next-state and RAM/handshake outputs; everything idles at 0 by default.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        merge_d   = merge_q;
        rdata_d   = rdata_q;
`ifdef MISALIGN_TRAP_EN
        err_d     = err_q;
`endif
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (state_q)
            IDLE: begin
                req_ready = rstn;
                if (rstn) begin
                    mem_addr = {{(32-AWIDTH){1'b0}}, word_idx};
                end
                if (accept) begin
`ifdef MISALIGN_TRAP_EN
                    if (misalign) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else
`endif
                    begin
`ifdef MISALIGN_TRAP_EN
                        err_d  = 1'b0;
`endif
                        mem_en = 1'b1;
                        if (!req_we) begin
                            rdata_d = lane_load;
                            state_d = RESP;
                        end else if (is_word(req_size)) begin
                            mem_wr    = 1'b1;
                            mem_wdata = req_wdata;
                            rdata_d   = '0;
                            state_d   = RESP;
                        end else begin
                            // Merge now against the word being read so the
                            // second cycle only has to write it back.
                            merge_d = lane_merge;
                            addr_d  = word_idx;
                            rdata_d = '0;
                            state_d = RMW;
                        end
                    end
                end
            end
            RMW: begin
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = {{(32-AWIDTH){1'b0}}, addr_q};
                mem_wdata = merge_q;
                state_d   = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state and response registers; reset abandons any transaction.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            rdata_q <= '0;
`ifdef MISALIGN_TRAP_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
`ifdef MISALIGN_TRAP_EN
            err_q   <= err_d;
`endif
        end
    end

    // Read-modify-write holding registers; only consumed while in RMW.
    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        merge_q <= merge_d;
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: byte-addressed reference memory model,
// directed transactions with cycle-exact checks, and a per-cycle monitor.
module tb_dmem_ctrl;

`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [1:0]  req_size = '0;
    logic        rsp_valid, rsp_err;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        mem_en, mem_wr;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int total = 0;
    int bad   = 0;

    dmem_ctrl #(.AWIDTH(8), .DWIDTH(32)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // RAM seen by the DUT (word array) and reference model (byte array).
    logic [31:0] ram [0:255];
    logic [7:0]  ref_b [0:1023];
    logic        poke_en = 1'b0;
    logic [7:0]  poke_idx = '0;
    logic [31:0] poke_val = '0;

    always @(posedge clk) begin
        if (poke_en) ram[poke_idx] <= poke_val;
        else if (mem_en && mem_wr) ram[mem_addr[7:0]] <= mem_wdata;
    end
    assign mem_rdata = ram[mem_addr[7:0]];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t expq[$];
    exp_t e;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int w);
        return {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]};
    endfunction

    // Reference behaviour: aligned byte-granular access on the byte array.
    function automatic void model_access(input logic we, input logic [31:0] addr,
                                         input logic [1:0] size, input logic uns,
                                         input logic [31:0] wd, output logic [31:0] rd,
                                         output logic err, output logic acc, output int base);
        int nb;
        int a;
        logic [31:0] v;
        nb   = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        a    = int'(addr[9:0]);
        err  = 1'b0;
        rd   = '0;
        acc  = 1'b1;
        base = a - (a % nb);
        if (TRAP && (a % nb) != 0) begin
            err = 1'b1;
            acc = 1'b0;
            return;
        end
        if (we) begin
            for (int k = 0; k < nb; k++) ref_b[base+k] = wd[8*k +: 8];
        end else begin
            v = '0;
            for (int k = 0; k < nb; k++) v = v | (32'(ref_b[base+k]) << (8*k));
            if (!uns && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
            rd = v;
        end
    endfunction

    task automatic poke(input int idx, input logic [31:0] v);
        poke_idx = idx[7:0];
        poke_val = v;
        poke_en  = 1'b1;
        @(posedge clk); #1;
        poke_en  = 1'b0;
        for (int k = 0; k < 4; k++) ref_b[idx*4+k] = v[8*k +: 8];
    endtask

    // One full transaction, started just after a rising edge in IDLE.
    task automatic do_req(input string nm, input logic we, input logic [31:0] addr,
                          input logic [1:0] size, input logic uns, input logic [31:0] wd,
                          input int hold, output logic [31:0] got, output logic got_err);
        logic [31:0] erd, merged, widx;
        logic eerr, acc, rmw;
        int base;
        model_access(we, addr, size, uns, wd, erd, eerr, acc, base);
        rmw    = we && !size[1] && acc;
        widx   = 32'(addr[9:2]);
        merged = ref_word(base / 4);
        expq.push_back('{rdata: erd, err: eerr});
        req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
        req_unsigned = uns; req_wdata = wd;
        rsp_ready = (hold == 0);
        @(negedge clk);
        chk({nm, ".req_ready"}, 32'(req_ready), 32'd1);
        chk({nm, ".mem_en"}, 32'(mem_en), 32'(acc));
        if (acc) begin
            chk({nm, ".mem_addr"}, mem_addr, widx);
            chk({nm, ".mem_wr"}, 32'(mem_wr), 32'(we && size[1]));
            if (we && size[1]) chk({nm, ".mem_wdata"}, mem_wdata, wd);
        end
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 1'b0; req_wdata = '0;
        if (rmw) begin
            @(negedge clk);
            chk({nm, ".rmw_wr"}, 32'(mem_en && mem_wr), 32'd1);
            chk({nm, ".rmw_addr"}, mem_addr, widx);
            chk({nm, ".rmw_wdata"}, mem_wdata, merged);
            chk({nm, ".rmw_rsp_valid"}, 32'(rsp_valid), 32'd0);
            @(posedge clk); #1;
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({nm, ".hold_valid"}, 32'(rsp_valid), 32'd1);
            chk({nm, ".hold_rdata"}, rsp_rdata, erd);
            chk({nm, ".hold_ready"}, 32'(req_ready), 32'd0);
            chk({nm, ".hold_mem_en"}, 32'(mem_en), 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk({nm, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
        got     = rsp_rdata;
        got_err = rsp_err;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk({nm, ".rsp_done"}, 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
    endtask

    // Per-cycle monitor: idle RAM bus quiet, address range, response scoreboard.
    always @(negedge clk) begin
        if (rstn) begin
            total++;
            if (!mem_en) begin
                if (mem_wr !== 1'b0 || mem_wdata !== 32'd0) begin
                    bad++;
                    $display("FAIL idle_bus: wr=%b wdata=%h expected 0/0", mem_wr, mem_wdata);
                end
            end else if (mem_addr[31:8] !== 24'd0) begin
                bad++;
                $display("FAIL mem_addr_range: got %h expected upper bits 0", mem_addr);
            end
            if (rsp_valid && rsp_ready) begin
                total++;
                if (expq.size() == 0) begin
                    bad++;
                    $display("FAIL rsp_unexpected: got rdata %h with no pending expectation", rsp_rdata);
                end else begin
                    e = expq.pop_front();
                    if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
                        bad++;
                        $display("FAIL rsp_data: got %h/%b expected %h/%b",
                                 rsp_rdata, rsp_err, e.rdata, e.err);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        logic        gerr;
        rstn = 1'b1;
        #1 rstn = 1'b0;
        for (int i = 0; i < 1024; i++) ref_b[i] = 8'h00;
        for (int i = 0; i < 16; i++) poke(i, 32'h0);
        @(negedge clk);
        chk("rst.req_ready", 32'(req_ready), 0);
        chk("rst.rsp_valid", 32'(rsp_valid), 0);
        chk("rst.rsp_err",   32'(rsp_err), 0);
        chk("rst.mem_en",    32'(mem_en), 0);
        chk("rst.mem_wr",    32'(mem_wr), 0);
        chk("rst.rsp_rdata", rsp_rdata, 0);
        chk("rst.mem_wdata", mem_wdata, 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;

        poke(4, 32'hDEAD_BEEF);
        do_req("ldw", 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 0, got, gerr);
        chk("ldw.literal", got, 32'hDEAD_BEEF);

        poke(4, 32'h1122_3344);
        do_req("stb", 1'b1, 32'h13, 2'b00, 1'b0, 32'h0000_00AA, 0, got, gerr);
        chk("stb.ram_literal", ram[4], 32'hAA22_3344);
        chk("stb.rdata_zero", got, 32'h0);

        poke(4, 32'h0080_0000);
        do_req("ldb_s", 1'b0, 32'h12, 2'b00, 1'b0, 32'h0, 0, got, gerr);
        chk("ldb_s.literal", got, 32'hFFFF_FF80);
        do_req("ldb_u", 1'b0, 32'h12, 2'b00, 1'b1, 32'h0, 0, got, gerr);
        chk("ldb_u.literal", got, 32'h0000_0080);

        poke(5, 32'hCAFE_BABE);
        do_req("sth", 1'b1, 32'h16, 2'b01, 1'b0, 32'hFFFF_1234, 0, got, gerr);
        chk("sth.ram_literal", ram[5], 32'h1234_BABE);
        do_req("ldh_u", 1'b0, 32'h14, 2'b01, 1'b1, 32'h0, 0, got, gerr);
        chk("ldh_u.literal", got, 32'h0000_BABE);
        do_req("ldh_s", 1'b0, 32'h14, 2'b01, 1'b0, 32'h0, 0, got, gerr);
        chk("ldh_s.literal", got, 32'hFFFF_BABE);
        do_req("ldh_hold", 1'b0, 32'h16, 2'b01, 1'b0, 32'h0, 3, got, gerr);
        chk("ldh_hold.literal", got, 32'h0000_1234);

        do_req("stw", 1'b1, 32'h20, 2'b10, 1'b0, 32'h5566_7788, 0, got, gerr);
        chk("stw.ram_literal", ram[8], 32'h5566_7788);
        do_req("ld_sz3", 1'b0, 32'h20, 2'b11, 1'b0, 32'h0, 1, got, gerr);
        chk("ld_sz3.literal", got, 32'h5566_7788);

        poke(4, 32'hDEAD_BEEF);
        do_req("ldw_mis", 1'b0, 32'h11, 2'b10, 1'b0, 32'h0, 0, got, gerr);
        chk("ldw_mis.rdata", got, TRAP ? 32'h0 : 32'hDEAD_BEEF);
        chk("ldw_mis.err", 32'(gerr), 32'(TRAP));
        do_req("sth_mis", 1'b1, 32'h15, 2'b01, 1'b0, 32'h0000_5678, 0, got, gerr);
        chk("sth_mis.ram", ram[5], TRAP ? 32'h1234_BABE : 32'h1234_5678);

        // Reset during the write cycle of a read-modify-write.
        poke(6, 32'h0102_0304);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h18; req_size = 2'b00;
        req_unsigned = 1'b0; req_wdata = 32'h0000_00EE; rsp_ready = 1'b0;
        @(negedge clk);
        chk("rst_rmw.accept", 32'(mem_en && !mem_wr), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 1'b0; req_wdata = '0;
        @(negedge clk);
        chk("rst_rmw.in_rmw", 32'(mem_wr), 32'd1);
        #1 rstn = 1'b0;
        #1;
        chk("rst_rmw.outs", {25'd0, req_ready, rsp_valid, rsp_err, mem_en, mem_wr,
                             |rsp_rdata, |mem_wdata}, 32'd0);
        chk("rst_rmw.mem_addr", mem_addr, 32'd0);
        @(posedge clk); #1;
        chk("rst_rmw.no_write", ram[6], 32'h0102_0304);
        rstn = 1'b1;
        @(posedge clk); #1;
        do_req("after_rst", 1'b0, 32'h18, 2'b10, 1'b0, 32'h0, 0, got, gerr);
        chk("after_rst.literal", got, 32'h0102_0304);

        for (int w = 4; w < 9; w++) chk("final_ram", ram[w], ref_word(w));
        chk("queue_drained", 32'(expq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
